sd_resp_rx: RTL and testbench
=============================

Name: sd_resp_rx

Overview:
Host-side receiver for SD-bus CMD-line responses, the counterpart of our command CRC7 generator. It waits for the card's start bit after a command is issued, deserialises one 48-bit response frame and checks CRC7 (x^7+x^3+1) on the fly. It also checks the framing bits and enforces an NCR timeout. It sits between the CMD-line pin sampler and the SD command sequencer, and reports the index and argument plus error flags once per frame.

Parameters:
TIMEOUT_BITS, 64, number of sd_bit_en strobes to wait for a start bit before declaring timeout (NCR limit)
CNT_W, $clog2(TIMEOUT_BITS+1), width of the wait counter (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sd_bit_en  in  1  one-cycle strobe; cmd_in is sampled only on cycles where it is 1 (SD clock rising edge)
cmd_in  in  1  registered CMD line level
arm  in  1  pulse: begin listening for a response (issued when the command's end bit has been sent)
crc_skip  in  1  latched at arm; 1 = R3-type response, CRC7 not checked
busy  out  1  high from accepted arm until result pulse
resp_valid  out  1  one-cycle pulse: frame complete, fields and flags valid
resp_idx  out  6  frame bits [2:7], command index
resp_arg  out  32  frame bits [8:39], argument/status
crc_err  out  1  valid with resp_valid; CRC7 mismatch (forced 0 when crc_skip latched)
frame_err  out  1  valid with resp_valid; transmission bit != 0 or end bit != 1
timeout  out  1  one-cycle pulse: no start bit within TIMEOUT_BITS strobes

Behaviour:
- Reset: state IDLE; busy, resp_valid, timeout, crc_err and frame_err are 0; resp_idx=0 and resp_arg=0; CRC register=0; counters=0.
- Frame bits are numbered 0..47 in line order (MSB first): 0 start=0, 1 transmission bit (0 for card->host), 2-7 index, 8-39 argument, 40-46 CRC7, 47 end=1.
- CRC: 7-bit LFSR, initial value 0, polynomial x^7+x^3+1. It advances on frame bits 0..39 only. On each step fb = crc[6] ^ bit; crc = {crc[5:3], crc[2]^fb, crc[1:0], fb}. Bits 40..46 are shifted into a separate received-CRC register and compared.
- States:
  - IDLE: arm=1 -> WAIT; latch crc_skip; clear wait counter; busy=1 from the next cycle.
  - WAIT: on each sd_bit_en, if cmd_in=0 -> SHIFT. This bit is frame bit 0 and is fed to the CRC. Otherwise increment the wait counter. When the counter reaches TIMEOUT_BITS on a strobe with cmd_in=1 -> IDLE, with a timeout pulse on that same transition cycle. Start bit on the TIMEOUT_BITS-th strobe is accepted (counter checked after the start test).
  - SHIFT: on each sd_bit_en, capture the next frame bit and increment the 6-bit bit counter. After bit 47 is captured -> DONE.
  - DONE: single cycle; drive resp_valid=1 and flags; -> IDLE; busy drops in the same cycle resp_valid is high.
- Latency: resp_valid rises on the clk cycle after the strobe that samples bit 47. Timeout is registered the cycle after the final waiting strobe.
- sd_bit_en low: the state machine holds; any number of idle cycles between strobes is legal.
- arm while busy: ignored; the frame in progress is unaffected. arm and sd_bit_en in the same IDLE cycle: that strobe is not sampled.
- Output hold: resp_idx and resp_arg hold their values until the next resp_valid; flags are meaningful only while resp_valid is high.
- Simultaneous errors: crc_err and frame_err are reported independently; both may be 1.
- rst mid-frame: immediate return to IDLE with all outputs as at reset; no resp_valid or timeout pulse.

Decomposition:
- Package sd_pkg holds:
  - CRC7_POLY = 7'h09
  - SD_FRAME_BITS = 48
  - SD_CRC_FIRST = 40
  - rx state enum {IDLE, WAIT, SHIFT, DONE}
  - function crc7_step(crc, bit), shared with the command transmitter
- Sub-module sd_crc7 (serial CRC7 with clear/enable) is natural and is reused by the transmitter.

Test Plan:
- Good R7: arm, 3 idle strobes, then 08 00 00 01 AA 13 serially -> one resp_valid with resp_idx=8, resp_arg=32'h000001AA, crc_err=0, frame_err=0; busy low afterwards.
- Corrupt CRC: same frame with argument bit 0 flipped (…01 AB 13) -> resp_valid with crc_err=1, frame_err=0, resp_arg=32'h000001AB.
- Framing: 08 00 00 01 AA 12 (end bit 0) -> frame_err=1, crc_err=0. Frame with transmission bit 1 (first byte 0x48, correct CRC appended) -> frame_err=1.
- R3 with crc_skip=1: 3F 00 FF 80 00 FF -> resp_idx=6'h3F, resp_arg=32'h00FF8000, crc_err=0, frame_err=0.
- Timeout: arm, hold cmd_in=1 for 64 strobes -> timeout pulse exactly once after the 64th strobe, no resp_valid. Start bit on strobe 64 -> frame accepted, no timeout.
- Reset/arm robustness: rst after 20 bits of a frame -> all outputs at reset values, no pulses; a following arm plus good R7 decodes correctly. A second arm mid-frame -> ignored, single resp_valid.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the SD CMD-line response receiver and command transmitter.
package sd_pkg;

   localparam logic [6:0] CRC7_POLY     = 7'h09;  // x^7 + x^3 + 1
   localparam int         SD_FRAME_BITS = 48;
   localparam int         SD_CRC_FIRST  = 40;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      SHIFT,
      DONE
   } rx_state_e;

   // One serial CRC7 step: feedback = msb ^ data bit, then shift and fold in the polynomial.
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
      logic fb;
      fb = crc[6] ^ b;
      return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator with synchronous clear (priority) and advance enable.
module sd_crc7
   import sd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic [6:0] crc
);

   logic [6:0] crc_q, crc_d;

   // Next CRC value: clear wins over advance, otherwise hold.
   always_comb begin
      crc_d = crc_q;
      if (clr)
         crc_d = 7'h00;
      else if (en)
         crc_d = crc7_step(crc_q, bit_in);
   end

   // CRC register.
   always_ff @(posedge clk) begin
      if (rst)
         crc_q <= 7'h00;
      else
         crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/sd_resp_rx.sv
// SD CMD-line response receiver: waits for the start bit (with NCR timeout),
// deserialises a 48-bit frame, checks CRC7 and framing bits.
module sd_resp_rx
   import sd_pkg::*;
#(
   parameter  int TIMEOUT_BITS = 64,
   localparam int CNT_W        = $clog2(TIMEOUT_BITS + 1)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sd_bit_en,
   input  logic        cmd_in,
   input  logic        arm,
   input  logic        crc_skip,
   output logic        busy,
   output logic        resp_valid,
   output logic [5:0]  resp_idx,
   output logic [31:0] resp_arg,
   output logic        crc_err,
   output logic        frame_err,
   output logic        timeout
);

   rx_state_e         state_q, state_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [5:0]        bit_cnt_q, bit_cnt_d;
   logic              skip_q, skip_d;
   logic              tx_bad_q, tx_bad_d;
   logic [5:0]        idx_sh_q, idx_sh_d;
   logic [31:0]       arg_sh_q, arg_sh_d;
   logic [6:0]        rx_crc_q, rx_crc_d;
   logic [5:0]        resp_idx_q, resp_idx_d;
   logic [31:0]       resp_arg_q, resp_arg_d;
   logic              crc_err_q, crc_err_d;
   logic              frame_err_q, frame_err_d;
   logic              timeout_q, timeout_d;
   logic              crc_clr, crc_en;
   logic [6:0]        crc_calc;
   logic [CNT_W-1:0]  wait_inc;

   sd_crc7 u_crc (
      .clk    (clk),
      .rst    (rst),
      .clr    (crc_clr),
      .en     (crc_en),
      .bit_in (cmd_in),
      .crc    (crc_calc)
   );

   assign wait_inc = wait_cnt_q + CNT_W'(1);

   // Next-state logic: frame sequencing, field shifting and result capture.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      skip_d      = skip_q;
      tx_bad_d    = tx_bad_q;
      idx_sh_d    = idx_sh_q;
      arg_sh_d    = arg_sh_q;
      rx_crc_d    = rx_crc_q;
      resp_idx_d  = resp_idx_q;
      resp_arg_d  = resp_arg_q;
      crc_err_d   = crc_err_q;
      frame_err_d = frame_err_q;
      timeout_d   = 1'b0;
      crc_clr     = 1'b0;
      crc_en      = 1'b0;
      case (state_q)
         IDLE: begin
            // A strobe coinciding with arm is deliberately not sampled.
            if (arm) begin
               state_d    = WAIT;
               skip_d     = crc_skip;
               wait_cnt_d = '0;
               bit_cnt_d  = '0;
               tx_bad_d   = 1'b0;
               crc_clr    = 1'b1;
            end
         end
         WAIT: begin
            if (sd_bit_en) begin
               // Start bit is tested before the limit so the last strobe can still start a frame.
               if (!cmd_in) begin
                  state_d   = SHIFT;
                  bit_cnt_d = 6'd1;
                  crc_en    = 1'b1;
               end else begin
                  wait_cnt_d = wait_inc;
                  if (wait_inc == CNT_W'(TIMEOUT_BITS)) begin
                     state_d   = IDLE;
                     timeout_d = 1'b1;
                  end
               end
            end
         end
         SHIFT: begin
            if (sd_bit_en) begin
               bit_cnt_d = bit_cnt_q + 6'd1;
               crc_en    = (bit_cnt_q < 6'(SD_CRC_FIRST));
               if (bit_cnt_q == 6'd1)
                  tx_bad_d = cmd_in;
               else if (bit_cnt_q < 6'd8)
                  idx_sh_d = {idx_sh_q[4:0], cmd_in};
               else if (bit_cnt_q < 6'(SD_CRC_FIRST))
                  arg_sh_d = {arg_sh_q[30:0], cmd_in};
               else if (bit_cnt_q < 6'(SD_FRAME_BITS - 1))
                  rx_crc_d = {rx_crc_q[5:0], cmd_in};
               else begin
                  // End bit: publish fields and flags together.
                  state_d     = DONE;
                  resp_idx_d  = idx_sh_q;
                  resp_arg_d  = arg_sh_q;
                  crc_err_d   = !skip_q && (crc_calc != rx_crc_q);
                  frame_err_d = tx_bad_q || !cmd_in;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         skip_q      <= 1'b0;
         tx_bad_q    <= 1'b0;
         idx_sh_q    <= '0;
         arg_sh_q    <= '0;
         rx_crc_q    <= '0;
         resp_idx_q  <= '0;
         resp_arg_q  <= '0;
         crc_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         skip_q      <= skip_d;
         tx_bad_q    <= tx_bad_d;
         idx_sh_q    <= idx_sh_d;
         arg_sh_q    <= arg_sh_d;
         rx_crc_q    <= rx_crc_d;
         resp_idx_q  <= resp_idx_d;
         resp_arg_q  <= resp_arg_d;
         crc_err_q   <= crc_err_d;
         frame_err_q <= frame_err_d;
         timeout_q   <= timeout_d;
      end
   end

   assign busy       = (state_q == WAIT) || (state_q == SHIFT);
   assign resp_valid = (state_q == DONE);
   assign resp_idx   = resp_idx_q;
   assign resp_arg   = resp_arg_q;
   assign crc_err    = resp_valid & crc_err_q;
   assign frame_err  = resp_valid & frame_err_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_sd_resp_rx.sv
// Directed bench for sd_resp_rx: good/corrupt/framing/R3 frames, timeout, reset and arm robustness.
module tb_sd_resp_rx;

   logic        clk = 1'b0;
   logic        rst, sd_bit_en, cmd_in, arm, crc_skip;
   logic        busy, resp_valid, crc_err, frame_err, timeout;
   logic [5:0]  resp_idx;
   logic [31:0] resp_arg;

   int compared = 0;
   int failed   = 0;
   int nvalid   = 0;
   int ntimeout = 0;
   int v0, t0;

   localparam logic [47:0] R7_GOOD = 48'h08_0000_01AA_13;
   localparam logic [47:0] R7_BAD  = 48'h08_0000_01AB_13;
   localparam logic [47:0] R7_END0 = 48'h08_0000_01AA_12;
   localparam logic [47:0] R7_TX1  = 48'h48_0000_01AA_87;
   localparam logic [47:0] R3_RESP = 48'h3F_00FF_8000_FF;

   sd_resp_rx #(.TIMEOUT_BITS(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .sd_bit_en  (sd_bit_en),
      .cmd_in     (cmd_in),
      .arm        (arm),
      .crc_skip   (crc_skip),
      .busy       (busy),
      .resp_valid (resp_valid),
      .resp_idx   (resp_idx),
      .resp_arg   (resp_arg),
      .crc_err    (crc_err),
      .frame_err  (frame_err),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   // Pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (resp_valid) nvalid <= nvalid + 1;
      if (timeout)    ntimeout <= ntimeout + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      cmd_in    = b;
      sd_bit_en = 1'b1;
      @(negedge clk);
      sd_bit_en = 1'b0;
      cmd_in    = 1'b1;
   endtask

   task automatic send_bits(input logic [47:0] f, input int from, input int to);
      for (int i = from; i <= to; i++) send_bit(f[47-i]);
   endtask

   task automatic do_arm(input logic skip);
      @(negedge clk);
      arm      = 1'b1;
      crc_skip = skip;
      @(negedge clk);
      arm      = 1'b0;
      crc_skip = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Called right at the negedge after the bit-47 strobe.
   task automatic check_resp(input string tag, input logic [5:0] idx, input logic [31:0] argv,
                             input logic ce, input logic fe);
      check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, "_idx"},   {26'd0, resp_idx}, {26'd0, idx});
      check({tag, "_arg"},   resp_arg, argv);
      check({tag, "_crc"},   {31'd0, crc_err}, {31'd0, ce});
      check({tag, "_frm"},   {31'd0, frame_err}, {31'd0, fe});
      check({tag, "_busy"},  {31'd0, busy}, 32'd0);
      v0 = nvalid;
      idle(3);
      check({tag, "_npulse"}, nvalid - v0, 32'd1);
      check({tag, "_vlow"},  {31'd0, resp_valid}, 32'd0);
      check({tag, "_hold"},  resp_arg, argv);
   endtask

   initial begin
      rst = 1'b1; sd_bit_en = 1'b0; cmd_in = 1'b1; arm = 1'b0; crc_skip = 1'b0;
      idle(3);
      rst = 1'b0;
      idle(1);

      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_tmo",   {31'd0, timeout}, 32'd0);
      check("rst_idx",   {26'd0, resp_idx}, 32'd0);
      check("rst_arg",   resp_arg, 32'd0);
      check("rst_flags", {30'd0, crc_err, frame_err}, 32'd0);

      // Good R7 after three idle strobes.
      do_arm(1'b0);
      check("r7_busy", {31'd0, busy}, 32'd1);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      send_bits(R7_GOOD, 0, 47);
      check_resp("r7", 6'd8, 32'h0000_01AA, 1'b0, 1'b0);

      // Corrupted argument bit.
      do_arm(1'b0);
      send_bits(R7_BAD, 0, 47);
      check_resp("badcrc", 6'd8, 32'h0000_01AB, 1'b1, 1'b0);

      // End bit 0.
      do_arm(1'b0);
      send_bits(R7_END0, 0, 47);
      check_resp("end0", 6'd8, 32'h0000_01AA, 1'b0, 1'b1);

      // Transmission bit 1 with matching CRC.
      do_arm(1'b0);
      send_bits(R7_TX1, 0, 47);
      check_resp("tx1", 6'd8, 32'h0000_01AA, 1'b0, 1'b1);

      // R3 with CRC check disabled.
      do_arm(1'b1);
      send_bits(R3_RESP, 0, 47);
      check_resp("r3", 6'h3F, 32'h00FF_8000, 1'b0, 1'b0);

      // Timeout after 64 strobes with the line high.
      v0 = nvalid; t0 = ntimeout;
      do_arm(1'b0);
      for (int i = 0; i < 63; i++) send_bit(1'b1);
      check("tmo_pre",  {31'd0, timeout}, 32'd0);
      check("tmo_busy", {31'd0, busy}, 32'd1);
      send_bit(1'b1);
      check("tmo_pulse", {31'd0, timeout}, 32'd1);
      check("tmo_idle",  {31'd0, busy}, 32'd0);
      idle(4);
      check("tmo_once",  ntimeout - t0, 32'd1);
      check("tmo_novld", nvalid - v0, 32'd0);

      // Start bit on the 64th strobe is still accepted.
      t0 = ntimeout;
      do_arm(1'b0);
      for (int i = 0; i < 63; i++) send_bit(1'b1);
      send_bits(R7_GOOD, 0, 47);
      check_resp("late", 6'd8, 32'h0000_01AA, 1'b0, 1'b0);
      check("late_notmo", ntimeout - t0, 32'd0);

      // Reset mid-frame after a frame with a nonzero R3 argument on the outputs.
      do_arm(1'b1);
      send_bits(R3_RESP, 0, 47);
      idle(2);
      v0 = nvalid; t0 = ntimeout;
      do_arm(1'b0);
      send_bits(R7_BAD, 0, 19);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check("mrst_busy", {31'd0, busy}, 32'd0);
      check("mrst_idx",  {26'd0, resp_idx}, 32'd0);
      check("mrst_arg",  resp_arg, 32'd0);
      send_bits(R7_BAD, 20, 47);
      idle(3);
      check("mrst_nopulse", (nvalid - v0) + (ntimeout - t0), 32'd0);
      do_arm(1'b0);
      send_bits(R7_GOOD, 0, 47);
      check_resp("postrst", 6'd8, 32'h0000_01AA, 1'b0, 1'b0);

      // Second arm mid-frame is ignored.
      do_arm(1'b0);
      send_bits(R7_GOOD, 0, 19);
      do_arm(1'b1);
      send_bits(R7_GOOD, 20, 47);
      check_resp("rearm", 6'd8, 32'h0000_01AA, 1'b0, 1'b0);

      // Strobe with a 0 in the arm cycle must not be taken as a start bit.
      @(negedge clk);
      arm = 1'b1; sd_bit_en = 1'b1; cmd_in = 1'b0;
      @(negedge clk);
      arm = 1'b0; sd_bit_en = 1'b0; cmd_in = 1'b1;
      send_bits(R7_GOOD, 0, 47);
      check_resp("armstb", 6'd8, 32'h0000_01AA, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
